// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath (master) and the
// hazard controller (slave).
interface pipeline_hazard_ctrl_if #(
  parameter int unsigned REG_W = 5
);
  logic             idex_memread;
  logic [REG_W-1:0] idex_rt;
  logic [REG_W-1:0] ifid_rs;
  logic [REG_W-1:0] ifid_rt;
  logic             ifid_uses_rt;
  logic             mc_start;
  logic             exmem_br_taken;

  logic             pc_write;
  logic             ifid_write;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             idex_flush;
  logic             mc_done;
  logic [15:0]      stall_cycles;

  modport master (
    output idex_memread, idex_rt, ifid_rs, ifid_rt, ifid_uses_rt,
           mc_start, exmem_br_taken,
    input  pc_write, ifid_write, ifid_flush, idex_bubble, idex_flush,
           mc_done, stall_cycles
  );

  modport slave (
    input  idex_memread, idex_rt, ifid_rs, ifid_rt, ifid_uses_rt,
           mc_start, exmem_br_taken,
    output pc_write, ifid_write, ifid_flush, idex_bubble, idex_flush,
           mc_done, stall_cycles
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// IF/ID + ID/EX hazard sequencer: load-use stall, branch squash, multi-cycle hold.
// Optional stall statistics counter enabled by defining HAZ_STATS_EN.
module pipeline_hazard_ctrl #(
  parameter int unsigned MC_LAT = 4,
  parameter int unsigned REG_W  = 5
) (
  input logic                   clk,
  input logic                   rst,
  pipeline_hazard_ctrl_if.slave hz
);

  typedef enum logic {
    RUN     = 1'b0,
    MC_WAIT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [3:0]       r_cnt;
  logic [3:0]       w_cnt_next;
  logic             r_mc_done;
  logic             w_mc_done_next;

  logic [REG_W-1:0] w_idex_rt;
  logic [REG_W-1:0] w_ifid_rs;
  logic [REG_W-1:0] w_ifid_rt;
  logic             w_lu;

  logic             w_pc_write;
  logic             w_ifid_write;
  logic             w_ifid_flush;
  logic             w_idex_bubble;
  logic             w_idex_flush;

  assign w_idex_rt = hz.idex_rt;
  assign w_ifid_rs = hz.ifid_rs;
  assign w_ifid_rt = hz.ifid_rt;

  // Register 0 is hardwired, so a load targeting it never creates a hazard.
  assign w_lu = hz.idex_memread && (w_idex_rt != '0) &&
                ((w_idex_rt == w_ifid_rs) ||
                 (hz.ifid_uses_rt && (w_idex_rt == w_ifid_rt)));

  always_comb begin
    w_pc_write     = 1'b1;
    w_ifid_write   = 1'b1;
    w_ifid_flush   = 1'b0;
    w_idex_bubble  = 1'b0;
    w_idex_flush   = 1'b0;
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_mc_done_next = 1'b0;

    if (rst) begin
      w_pc_write    = 1'b0;
      w_ifid_write  = 1'b0;
      w_idex_bubble = 1'b1;
      w_state_next  = RUN;
      w_cnt_next    = '0;
    end else begin
      unique case (r_state)
        RUN: begin
          if (hz.exmem_br_taken) begin
            w_ifid_flush = 1'b1;
            w_idex_flush = 1'b1;
          end else if (w_lu) begin
            w_pc_write    = 1'b0;
            w_ifid_write  = 1'b0;
            w_idex_bubble = 1'b1;
          end else if (hz.mc_start && !r_mc_done) begin
            // The entry cycle is itself the first of the MC_LAT stall cycles.
            w_pc_write    = 1'b0;
            w_ifid_write  = 1'b0;
            w_idex_bubble = 1'b1;
            w_state_next  = MC_WAIT;
            w_cnt_next    = 4'(MC_LAT - 2);
          end
        end
        MC_WAIT: begin
          if (hz.exmem_br_taken) begin
            w_ifid_flush = 1'b1;
            w_idex_flush = 1'b1;
            w_state_next = RUN;
            w_cnt_next   = '0;
          end else begin
            w_pc_write    = 1'b0;
            w_ifid_write  = 1'b0;
            w_idex_bubble = 1'b1;
            if (r_cnt == '0) begin
              w_state_next   = RUN;
              w_mc_done_next = 1'b1;
            end else begin
              w_cnt_next = r_cnt - 4'd1;
            end
          end
        end
        default: begin
          w_state_next = RUN;
          w_cnt_next   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= RUN;
      r_cnt     <= '0;
      r_mc_done <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_mc_done <= w_mc_done_next;
    end
  end

  assign hz.pc_write    = w_pc_write;
  assign hz.ifid_write  = w_ifid_write;
  assign hz.ifid_flush  = w_ifid_flush;
  assign hz.idex_bubble = w_idex_bubble;
  assign hz.idex_flush  = w_idex_flush;
  assign hz.mc_done     = r_mc_done;

`ifdef HAZ_STATS_EN
  logic [15:0] r_stall_cycles;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cycles <= '0;
    end else if (!w_pc_write && (r_stall_cycles != '1)) begin
      r_stall_cycles <= r_stall_cycles + 16'd1;
    end
  end

  assign hz.stall_cycles = r_stall_cycles;
`else
  assign hz.stall_cycles = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized + directed bench for pipeline_hazard_ctrl against a cycle-level
// reference model that tracks remaining stall cycles as a plain integer.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned MC_LAT = 4;
  localparam int unsigned REG_W  = 5;

  logic clk;
  logic rst;

  pipeline_hazard_ctrl_if #(.REG_W(REG_W)) hz ();

  pipeline_hazard_ctrl #(
    .MC_LAT(MC_LAT),
    .REG_W (REG_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .hz (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: remaining MC_WAIT stall cycles, pending done pulse, stall count.
  int m_left   = 0;
  bit m_done   = 1'b0;
  int m_stalls = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_stats();
`ifdef HAZ_STATS_EN
    return 32'(m_stalls);
`else
    return 32'd0;
`endif
  endfunction

  function automatic logic [31:0] ctrl_vec();
    return 32'({hz.pc_write, hz.ifid_write, hz.ifid_flush, hz.idex_bubble, hz.idex_flush});
  endfunction

  task automatic model_reset();
    m_left   = 0;
    m_done   = 1'b0;
    m_stalls = 0;
  endtask

  // Ctrl vector order: {pc_write, ifid_write, ifid_flush, idex_bubble, idex_flush}
  task automatic cyc(input bit r, input bit mr, input int irt, input int rs, input int rt,
                     input bit urt, input bit ms, input bit br);
    bit         lu;
    bit         stall;
    logic [4:0] exp;
    @(negedge clk);
    rst                  = r;
    hz.idex_memread      = mr;
    hz.idex_rt           = REG_W'(irt);
    hz.ifid_rs           = REG_W'(rs);
    hz.ifid_rt           = REG_W'(rt);
    hz.ifid_uses_rt      = urt;
    hz.mc_start          = ms;
    hz.exmem_br_taken    = br;
    #1;
    if (r) model_reset();
    lu = mr && (irt != 0) && ((irt == rs) || (urt && (irt == rt)));
    stall = 1'b0;
    if (r)                                     exp = 5'b00010;
    else if (br)                               exp = 5'b11101;
    else if (m_left > 0 || lu || (ms && !m_done)) begin
      exp   = 5'b00010;
      stall = 1'b1;
    end else                                   exp = 5'b11000;
    check("ctrl", ctrl_vec(), 32'(exp));
    check("mc_done", 32'(hz.mc_done), 32'(m_done));
    check("stall_cycles", 32'(hz.stall_cycles), exp_stats());
    if (!r) begin
      if (stall && m_stalls < 65535) m_stalls++;
      if (br) begin
        m_left = 0;
        m_done = 1'b0;
      end else if (m_left > 0) begin
        m_left--;
        m_done = (m_left == 0);
      end else if (!lu && ms && !m_done) begin
        m_left = MC_LAT - 1;
        m_done = 1'b0;
      end else begin
        m_done = 1'b0;
      end
    end
  endtask

  int n_stall;
  int n_done;
  bit ms_lvl;

  initial begin
    rst = 1'b1;
    hz.idex_memread = 1'b0; hz.idex_rt = '0; hz.ifid_rs = '0; hz.ifid_rt = '0;
    hz.ifid_uses_rt = 1'b0; hz.mc_start = 1'b0; hz.exmem_br_taken = 1'b0;

    repeat (2) cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);

    // Load-use on rs, then defaults
    cyc(0, 1, 5, 5, 0, 0, 0, 0);
    check("lu_pc_write", 32'(hz.pc_write), 32'd0);
    cyc(0, 0, 5, 5, 0, 0, 0, 0);
    check("lu_release", ctrl_vec(), 32'h18);
    // rt hazard only counts when rt is a source
    cyc(0, 1, 7, 1, 7, 0, 0, 0);
    cyc(0, 1, 7, 1, 7, 1, 0, 0);
    // r0 never hazards
    cyc(0, 1, 0, 0, 0, 1, 0, 0);
    check("r0_no_stall", 32'(hz.pc_write), 32'd1);
    // Branch beats load-use
    cyc(0, 1, 5, 5, 0, 0, 0, 1);
    check("br_over_lu", ctrl_vec(), 32'h1D);

    // Held mc_start: exactly MC_LAT stalls then mc_done with pc_write=1
    n_stall = 0; n_done = 0;
    for (int i = 0; i < MC_LAT + 1; i++) begin
      cyc(0, 0, 0, 1, 2, 0, 1, 0);
      if (!hz.pc_write) n_stall++;
      if (hz.mc_done && hz.pc_write) n_done++;
    end
    check("mc_stall_len", 32'(n_stall), 32'(MC_LAT));
    check("mc_done_pulse", 32'(n_done), 32'd1);
    repeat (MC_LAT + 1) cyc(0, 0, 0, 0, 0, 0, 0, 0);

    // Branch in 2nd MC_WAIT cycle aborts without mc_done
    n_done = 0;
    cyc(0, 0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 1);
    check("mc_abort_flush", ctrl_vec(), 32'h1D);
    for (int i = 0; i < MC_LAT + 1; i++) begin
      cyc(0, 0, 0, 0, 0, 0, 0, 0);
      if (hz.mc_done) n_done++;
    end
    check("mc_abort_no_done", 32'(n_done), 32'd0);

    // Asynchronous reset in the middle of MC_WAIT
    cyc(0, 0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("async_rst_ctrl", ctrl_vec(), 32'h02);
    check("async_rst_done", 32'(hz.mc_done), 32'd0);
    check("async_rst_stats", 32'(hz.stall_cycles), 32'd0);
    cyc(1, 0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    check("post_rst_default", ctrl_vec(), 32'h18);
    cyc(0, 1, 3, 3, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);

    // Randomized traffic
    ms_lvl = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) ms_lvl = ~ms_lvl;
      cyc(($urandom_range(0, 255) == 0),
          1'($urandom_range(0, 1)),
          int'($urandom_range(0, 3)),
          int'($urandom_range(0, 3)),
          int'($urandom_range(0, 3)),
          1'($urandom_range(0, 1)),
          ms_lvl,
          ($urandom_range(0, 9) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
